// File: rtl/sram_interface.sv
// Single-transaction controller for an asynchronous off-chip SRAM.
// Holds address/data stable for a fixed enable window and pulses io_done.
module sram_interface #(
  parameter int ADDR_BITS     = 16,
  parameter int DATA_BITS     = 32,
  parameter int ACCESS_CYCLES = 2
) (
  input  logic                 clk,
  input  logic                 n_rst,
  input  logic                 start,
  input  logic                 writemode,
  input  logic [ADDR_BITS-1:0] i_address,
  input  logic [DATA_BITS-1:0] i_w_data,
  output logic [DATA_BITS-1:0] i_r_data,
  output logic                 io_done,
  output logic                 read_enable,
  output logic                 write_enable,
  output logic [ADDR_BITS-1:0] address,
  output logic [DATA_BITS-1:0] w_data,
  input  logic [DATA_BITS-1:0] r_data
);

  localparam int CW = $clog2(ACCESS_CYCLES) + 1;
  localparam logic [CW-1:0] CNT_INIT = CW'(ACCESS_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    DONE
  } state_t;

  state_t        state;
  logic          start_prev;
  logic          wmode;
  logic [CW-1:0] cnt;
  logic          launch;

  assign launch = start & ~start_prev & (state == IDLE);

  always_ff @(posedge clk) begin
    if (n_rst) begin
      state        <= IDLE;
      start_prev   <= 1'b0;
      wmode        <= 1'b0;
      cnt          <= '0;
      i_r_data     <= '0;
      io_done      <= 1'b0;
      read_enable  <= 1'b0;
      write_enable <= 1'b0;
      address      <= '0;
      w_data       <= '0;
    end else begin
      start_prev <= start;
      io_done    <= 1'b0;
      unique case (state)
        IDLE: begin
          if (launch) begin
            address      <= i_address;
            if (writemode)
              w_data     <= i_w_data;
            wmode        <= writemode;
            cnt          <= CNT_INIT;
            write_enable <= writemode;
            read_enable  <= ~writemode;
            state        <= ACCESS;
          end
        end
        ACCESS: begin
          // r_data is only sampled inside the read window
          if (cnt == '0) begin
            if (!wmode)
              i_r_data   <= r_data;
            write_enable <= 1'b0;
            read_enable  <= 1'b0;
            io_done      <= 1'b1;
            state        <= DONE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sram_interface.sv
// Bench for sram_interface: vector table plus scoreboard of pending
// transactions, checked against a behavioural SRAM on io_done.
module tb_sram_interface;

  localparam int AC = 2;

  logic        clk = 1'b0;
  logic        n_rst;
  logic        start;
  logic        writemode;
  logic [15:0] i_address;
  logic [31:0] i_w_data;
  logic [31:0] i_r_data;
  logic        io_done;
  logic        read_enable;
  logic        write_enable;
  logic [15:0] address;
  logic [31:0] w_data;
  logic [31:0] r_data;

  sram_interface #(
    .ADDR_BITS(16),
    .DATA_BITS(32),
    .ACCESS_CYCLES(AC)
  ) dut (
    .clk(clk),
    .n_rst(n_rst),
    .start(start),
    .writemode(writemode),
    .i_address(i_address),
    .i_w_data(i_w_data),
    .i_r_data(i_r_data),
    .io_done(io_done),
    .read_enable(read_enable),
    .write_enable(write_enable),
    .address(address),
    .w_data(w_data),
    .r_data(r_data)
  );

  always #5 clk = ~clk;

  logic [31:0] mem [0:65535];

  always @(posedge clk)
    if (write_enable)
      mem[address] <= w_data;

  assign r_data = read_enable ? mem[address] : 'x;

  typedef struct {
    logic        we;
    logic [15:0] addr;
    logic [31:0] wdata;
    int          hold;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t sb[$];
  vec_t tbl[8];

  int   n_vec = 0;
  int   n_err = 0;
  int   n_done = 0;
  int   n_exp = 0;
  int   en_cnt = 0;
  logic saw_we = 1'b0;
  logic saw_re = 1'b0;
  logic prev_done = 1'b0;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic mon_step();
    vec_t e;
    check("both_en", 32'(read_enable & write_enable), 32'd0);
    if (read_enable | write_enable) begin
      en_cnt++;
      saw_we = saw_we | write_enable;
      saw_re = saw_re | read_enable;
      if (sb.size() > 0) begin
        check("addr_hold", 32'(address), 32'(sb[0].addr));
        if (sb[0].we)
          check("wdata_hold", w_data, sb[0].wdata);
      end
    end
    if (io_done) begin
      n_done++;
      check("done_pulse", 32'(prev_done), 32'd0);
      if (sb.size() == 0) begin
        check("spurious_done", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        check("en_cycles", en_cnt, AC);
        check("we_seen", 32'(saw_we), 32'(e.we));
        check("re_seen", 32'(saw_re), 32'(!e.we));
        check("addr_done", 32'(address), 32'(e.addr));
        check("rd_data", i_r_data, e.exp_rd);
        if (e.we)
          check("sram_mem", mem[e.addr], e.wdata);
      end
      en_cnt = 0;
      saw_we = 1'b0;
      saw_re = 1'b0;
    end
    prev_done = io_done;
  endtask

  task automatic tick();
    @(negedge clk);
    mon_step();
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 40 && sb.size() > 0; i++)
      tick();
    if (sb.size() > 0) begin
      check("timeout", sb.size(), 32'd0);
      sb.delete();
    end
    tick();
    tick();
  endtask

  task automatic run(vec_t v);
    tick();
    writemode = v.we;
    i_address = v.addr;
    i_w_data  = v.we ? v.wdata : 32'h0BAD0BAD;
    start     = 1'b1;
    sb.push_back(v);
    n_exp++;
    for (int i = 0; i < v.hold; i++)
      tick();
    start = 1'b0;
    wait_idle();
  endtask

  task automatic check_zero(string tag);
    check({tag, "_rdata"}, i_r_data, 32'd0);
    check({tag, "_done"}, 32'(io_done), 32'd0);
    check({tag, "_re"}, 32'(read_enable), 32'd0);
    check({tag, "_we"}, 32'(write_enable), 32'd0);
    check({tag, "_addr"}, 32'(address), 32'd0);
    check({tag, "_wdata"}, w_data, 32'd0);
  endtask

  initial begin
    vec_t v;
    tbl[0] = '{1'b1, 16'h0001, 32'hAAAAAAAA, 2,  32'h00000000};
    tbl[1] = '{1'b0, 16'h0001, 32'h00000000, 2,  32'hAAAAAAAA};
    tbl[2] = '{1'b1, 16'h0003, 32'h55555555, 2,  32'hAAAAAAAA};
    tbl[3] = '{1'b0, 16'h0003, 32'h00000000, 2,  32'h55555555};
    tbl[4] = '{1'b1, 16'hFFFF, 32'h12345678, 1,  32'h55555555};
    tbl[5] = '{1'b0, 16'hFFFF, 32'h00000000, 10, 32'h12345678};
    tbl[6] = '{1'b1, 16'h0000, 32'hDEADBEEF, 10, 32'h12345678};
    tbl[7] = '{1'b0, 16'h0000, 32'h00000000, 1,  32'hDEADBEEF};

    n_rst     = 1'b1;
    start     = 1'b0;
    writemode = 1'b0;
    i_address = '0;
    i_w_data  = '0;
    repeat (3) tick();
    check_zero("reset");
    n_rst = 1'b0;
    repeat (2) tick();

    for (int i = 0; i < 8; i++)
      run(tbl[i]);

    // start re-asserted mid-window must be dropped
    tick();
    writemode = 1'b0;
    i_address = 16'h0001;
    start     = 1'b1;
    v = '{1'b0, 16'h0001, 32'h0, 0, 32'hAAAAAAAA};
    sb.push_back(v);
    n_exp++;
    tick();
    start = 1'b0;
    tick();
    i_address = 16'h00FF;
    start     = 1'b1;
    repeat (3) tick();
    start = 1'b0;
    wait_idle();
    repeat (3) tick();
    check("busy_addr", 32'(address), 32'h0001);

    // reset during the second cycle of a write window
    tick();
    writemode = 1'b1;
    i_address = 16'h0002;
    i_w_data  = 32'h12121212;
    start     = 1'b1;
    v = '{1'b1, 16'h0002, 32'h12121212, 0, 32'hAAAAAAAA};
    sb.push_back(v);
    tick();
    start = 1'b0;
    tick();
    check("mid_we", 32'(write_enable), 32'd1);
    n_rst = 1'b1;
    tick();
    check_zero("abort");
    n_rst = 1'b0;
    sb.delete();
    en_cnt = 0;
    saw_we = 1'b0;
    saw_re = 1'b0;
    repeat (5) tick();

    v = '{1'b0, 16'h0003, 32'h0, 2, 32'h55555555};
    run(v);
    v = '{1'b1, 16'h0004, 32'hC3C3C3C3, 2, 32'h55555555};
    run(v);

    check("done_count", n_done, n_exp);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/sram_interface.md
Name: sram_interface

Overview:
- Synchronous single-transaction controller between on-chip logic and an asynchronous off-chip SRAM, 16-bit word address, 32-bit data.
- Accepts one read or write request, drives the SRAM read_enable/write_enable/address/w_data pins for a fixed access window, and captures read data.
- Pulses io_done when the transaction completes.
- The external tristate data bus is resolved outside this block; the block only sees separate w_data (out) and r_data (in).

Parameters:
- ADDR_BITS, 16, width of i_address/address.
- DATA_BITS, 32, width of all data ports.
- ACCESS_CYCLES, 2, clock cycles an enable is held asserted per access (≥1).

Ports:
- clk  in  1  system clock, rising edge.
- n_rst  in  1  reset, synchronous, active-high (despite the name).
- start  in  1  request strobe; a transaction launches on its rising edge.
- writemode  in  1  1=write, 0=read; sampled at launch.
- i_address  in  ADDR_BITS  request address; sampled at launch.
- i_w_data  in  DATA_BITS  write data; sampled at launch.
- i_r_data  out  DATA_BITS  last captured read data.
- io_done  out  1  one-cycle completion pulse.
- read_enable  out  1  SRAM read strobe.
- write_enable  out  1  SRAM write strobe.
- address  out  ADDR_BITS  SRAM address.
- w_data  out  DATA_BITS  data driven toward the SRAM bus.
- r_data  in  DATA_BITS  data returned from the SRAM bus (high-Z/X when read_enable=0).

Behaviour:
- All outputs are registered.
- Reset (n_rst=1 at a clk edge):
  - state=IDLE; all outputs 0 (i_r_data, io_done, read_enable, write_enable, address, w_data); start-edge history register=0.
  - Reset aborts any in-flight access: enables drop on the same edge, no io_done.
- Start detection: start_prev registers start every cycle. launch = start & ~start_prev & (state==IDLE). Holding start high for many cycles yields exactly one transaction. Edges outside IDLE are ignored (not queued).
- States: IDLE, ACCESS, DONE.
  - IDLE:
    - Enables 0, io_done 0; address/w_data hold last values.
    - On launch: latch i_address→address, i_w_data→w_data (writes only; reads leave w_data unchanged), latch writemode, load counter=ACCESS_CYCLES-1, go ACCESS.
  - ACCESS:
    - write_enable=writemode, read_enable=~writemode. Never both high.
    - address and w_data stable for the whole window.
    - Counter decrements each cycle. When counter==0:
      - On a read, r_data is registered into i_r_data at that edge.
      - Both enables drop to 0; go DONE.
    - Enables are therefore high for exactly ACCESS_CYCLES cycles.
  - DONE: io_done=1 for exactly one cycle, enables 0, address still held (address never changes while an enable is high or on the edge it falls); go IDLE.
- Latency: launch detected at edge k → enable high at edges k..k+ACCESS_CYCLES-1 → io_done high for the cycle after edge k+ACCESS_CYCLES. A new launch is possible from the edge after io_done.
- i_r_data:
  - Changes only on read completion.
  - Writes leave it unchanged.
  - Holds its value indefinitely.
- X/Z on r_data outside the read window must not propagate into i_r_data.
- Counter width ≥ clog2(ACCESS_CYCLES)+1; no wrap issues at ACCESS_CYCLES=1 (single-cycle window, straight to DONE).

Test Plan:
1. Write: reset, then start rising with writemode=1, i_address=0x0001, i_w_data=0xAAAAAAAA, held 2 cycles.
   - write_enable high exactly 2 cycles with address=0x0001, w_data=0xAAAAAAAA.
   - read_enable stays 0.
   - io_done pulses 1 cycle later.
   - SRAM model location 1 = 0xAAAAAAAA.
2. Read-back: start edge with writemode=0, i_address=0x0001.
   - read_enable high 2 cycles.
   - i_r_data=0xAAAAAAAA after io_done.
   - write_enable never asserted.
3. Held start: start high for 10 cycles → exactly one io_done pulse; then a second start rising edge → a second transaction.
4. Busy ignore: start toggled 0→1 during ACCESS → ignored; only one io_done; address unchanged.
5. Reset mid-op: n_rst=1 during the second ACCESS cycle of a write to 0x0002.
   - Next edge: all outputs 0, no io_done.
   - A later transaction works normally.
6. Write preserves read data: read 0x0001 (0xAAAAAAAA), then write 0x55555555 to 0x0003 → i_r_data remains 0xAAAAAAAA.
